// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared word, state and queue-entry types for the fetch unit
package instruction_fetch_unit_pkg;
    typedef logic [31:0] word_t;
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t RUN    = 2'd0;
    localparam fetch_state_t SQUASH = 2'd1;
    localparam fetch_state_t HALTED = 2'd2;
    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: I-cache request, decode handshake and redirect/halt signals of the fetch unit
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;
    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    word_t instr;
    word_t instr_pc;
    word_t instr_npc;
    logic  instr_valid;
    logic  instr_ready;
    logic  redirect;
    word_t redirect_addr;
    logic  halt;
    logic  halted;
    modport master (
        output imemREN, imemaddr, instr, instr_pc, instr_npc, instr_valid, halted,
        input  ihit, imemload, instr_ready, redirect, redirect_addr, halt
    );
    modport slave (
        input  imemREN, imemaddr, instr, instr_pc, instr_npc, instr_valid, halted,
        output ihit, imemload, instr_ready, redirect, redirect_addr, halt
    );
endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// instruction_fetch_unit_fetch_queue: sync FIFO of fetched words; flush wins over a same-cycle push
module instruction_fetch_unit_fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [AW:0]  count
);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    assign head = mem[rd_ptr];
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, issues I-cache reads and queues fetched words for decode,
// squashing stale fetches on redirect and stopping for good on a consumed halt.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter word_t PCSTART = 32'h0000_0000,
    parameter int    QDEPTH  = 2
) (
    input logic CLK,
    input logic RST,
    instruction_fetch_unit_if.master bus
);
    localparam int AW = $clog2(QDEPTH);
    fetch_state_t state;
    word_t        pc;
    word_t        stale_addr;
    logic         drain;
    logic [AW:0]  count;
    fetch_entry_t head;
    logic         has_room;
    logic         pop;
    logic         halt_take;
    logic         push;
    logic         flush;
    logic         miss;
    // An outstanding request can only end by ihit, so room never shrinks under it
    assign has_room        = count < (AW+1)'(QDEPTH);
    assign bus.imemREN     = !RST && (state == RUN ? has_room : state == SQUASH ? 1'b1 : drain);
    assign bus.imemaddr    = state == RUN ? pc : stale_addr;
    assign bus.instr_valid = state == RUN && count != '0;
    assign bus.halted      = state == HALTED;
    assign pop             = bus.instr_valid && bus.instr_ready;
    assign halt_take       = pop && bus.halt;
    assign push            = state == RUN && bus.imemREN && bus.ihit;
    assign flush           = state == RUN && (bus.redirect || halt_take);
    assign miss            = bus.imemREN && !bus.ihit;
    assign bus.instr       = bus.instr_valid ? head.instr : '0;
    assign bus.instr_pc    = bus.instr_valid ? head.pc : '0;
    assign bus.instr_npc   = bus.instr_valid ? head.pc + 32'd4 : '0;
    instruction_fetch_unit_fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ('{instr: bus.imemload, pc: pc}),
        .head  (head),
        .count (count)
    );
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RUN;
            pc         <= PCSTART & ~32'd3;
            stale_addr <= '0;
            drain      <= 1'b0;
        end else if (state == RUN) begin
            if (halt_take) begin
                state      <= HALTED;
                stale_addr <= pc;
                drain      <= miss;
            end else if (bus.redirect) begin
                pc         <= bus.redirect_addr & ~32'd3;
                stale_addr <= pc;
                if (miss) state <= SQUASH;
            end else if (push) begin
                pc <= pc + 32'd4;
            end
        end else if (state == SQUASH) begin
            if (bus.redirect) pc <= bus.redirect_addr & ~32'd3;
            if (bus.ihit) state <= RUN;
        end else if (bus.ihit) begin
            drain <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenarios plus random traffic checked against a queue-level fetch model
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;
    localparam int QD = 2;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int checks = 0;
    int errors = 0;
    bit armed = 0;
    always #5 CLK = ~CLK;

    instruction_fetch_unit_if bus ();
    instruction_fetch_unit_if wbus ();
    instruction_fetch_unit #(.PCSTART(32'h0000_0000), .QDEPTH(QD)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    instruction_fetch_unit #(.PCSTART(32'hFFFF_FFF8), .QDEPTH(QD)) dut_w (.CLK(CLK), .RST(RST), .bus(wbus));

    // Model: queue of {instr, pc}, next PC, and the one request the cache may still owe us
    logic [63:0] q [$];
    logic [31:0] m_pc;
    logic [31:0] o_addr;
    bit o_pend;
    bit o_stale;
    bit m_halt;

    function automatic bit m_ren();
        return !RST && (o_pend || (!m_halt && q.size() < QD));
    endfunction
    function automatic logic [31:0] m_addr();
        return o_pend ? o_addr : m_pc;
    endfunction
    function automatic bit m_valid();
        return !m_halt && q.size() != 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin : model
        bit ren;
        bit pop;
        logic [31:0] a;
        ren = m_ren();
        a = m_addr();
        pop = m_valid() && bus.instr_ready;
        if (RST) begin
            q.delete();
            m_pc = 32'h0;
            o_pend = 0;
            o_stale = 0;
            m_halt = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (pop && bus.halt) begin
                m_halt = 1;
                q.delete();
                o_pend = ren && !bus.ihit;
                o_stale = o_pend;
                o_addr = a;
            end else if (m_halt) begin
                if (bus.ihit) o_pend = 0;
            end else if (bus.redirect) begin
                q.delete();
                m_pc = bus.redirect_addr & ~32'd3;
                o_pend = ren && !bus.ihit;
                o_stale = o_pend;
                o_addr = a;
            end else if (ren) begin
                if (bus.ihit) begin
                    if (!o_stale) begin
                        q.push_back({bus.imemload, a});
                        m_pc = a + 32'd4;
                    end
                    o_pend = 0;
                    o_stale = 0;
                end else begin
                    o_pend = 1;
                    o_addr = a;
                end
            end
        end
    end

    always @(negedge CLK) begin : compare
        logic [63:0] h;
        bit v;
        if (armed) begin
            v = m_valid();
            h = v ? q[0] : 64'd0;
            chk("imemREN", 32'(bus.imemREN), 32'(m_ren()));
            if (m_ren()) chk("imemaddr", bus.imemaddr, m_addr());
            chk("instr_valid", 32'(bus.instr_valid), 32'(v));
            chk("instr", bus.instr, h[63:32]);
            chk("instr_pc", bus.instr_pc, h[31:0]);
            chk("instr_npc", bus.instr_npc, v ? h[31:0] + 32'd4 : 32'd0);
            chk("halted", 32'(bus.halted), 32'(m_halt));
        end
    end

    always @(negedge CLK) begin
        #1 bus.imemload = $urandom;
    end

    task automatic do_reset();
        @(negedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        bus.ihit = 0; bus.imemload = 0; bus.instr_ready = 0;
        bus.redirect = 0; bus.redirect_addr = 0; bus.halt = 0;
        wbus.ihit = 1; wbus.imemload = 32'h1234_5678; wbus.instr_ready = 1;
        wbus.redirect = 0; wbus.redirect_addr = 0; wbus.halt = 0;
        @(posedge CLK);
        armed = 1;
        @(negedge CLK);
        chk("rst imemREN", 32'(bus.imemREN), 32'd0);
        chk("rst instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst halted", 32'(bus.halted), 32'd0);
        // 1: streaming fetch, plus the wrapping instance
        #1 RST = 0; bus.ihit = 1; bus.instr_ready = 1;
        #1 chk("s1 first addr", bus.imemaddr, 32'h0);
        chk("s6 first addr", wbus.imemaddr, 32'hFFFF_FFF8);
        @(negedge CLK);
        chk("s1 pc0", bus.instr_pc, 32'h0);
        chk("s1 npc0", bus.instr_npc, 32'h4);
        chk("s1 addr4", bus.imemaddr, 32'h4);
        chk("s6 pc0", wbus.instr_pc, 32'hFFFF_FFF8);
        chk("s6 addr1", wbus.imemaddr, 32'hFFFF_FFFC);
        @(negedge CLK);
        chk("s1 pc4", bus.instr_pc, 32'h4);
        chk("s1 addr8", bus.imemaddr, 32'h8);
        chk("s6 wrap addr", wbus.imemaddr, 32'h0);
        @(negedge CLK);
        chk("s6 wrap pc", wbus.instr_pc, 32'h0);
        // 2: backpressure fills the queue, then drains in order
        #1 bus.instr_ready = 0;
        do_reset();
        @(negedge CLK);
        @(negedge CLK);
        chk("s2 full ren", 32'(bus.imemREN), 32'd0);
        chk("s2 head0", bus.instr_pc, 32'h0);
        #1 bus.instr_ready = 1;
        @(negedge CLK);
        chk("s2 head4", bus.instr_pc, 32'h4);
        chk("s2 resume", bus.imemaddr, 32'h8);
        // 3: redirect while the request to 0x8 is outstanding
        #1 bus.ihit = 0; bus.redirect = 1; bus.redirect_addr = 32'h100;
        @(negedge CLK);
        chk("s3 hold addr", bus.imemaddr, 32'h8);
        chk("s3 no valid", 32'(bus.instr_valid), 32'd0);
        #1 bus.redirect = 0;
        @(negedge CLK);
        chk("s3 hold addr2", bus.imemaddr, 32'h8);
        #1 bus.ihit = 1;
        @(negedge CLK);
        chk("s3 target addr", bus.imemaddr, 32'h100);
        chk("s3 stale dropped", 32'(bus.instr_valid), 32'd0);
        @(negedge CLK);
        chk("s3 first pc", bus.instr_pc, 32'h100);
        // 4: redirect coincident with ihit
        #1 bus.redirect = 1; bus.redirect_addr = 32'h43;
        @(negedge CLK);
        chk("s4 addr", bus.imemaddr, 32'h40);
        chk("s4 dropped", 32'(bus.instr_valid), 32'd0);
        // 5: halt at 0xC with a simultaneous redirect
        #1 bus.redirect_addr = 32'h8;
        @(negedge CLK);
        #1 bus.redirect = 0;
        @(negedge CLK);
        @(negedge CLK);
        chk("s5 head C", bus.instr_pc, 32'hC);
        #1 bus.halt = 1; bus.redirect = 1; bus.redirect_addr = 32'h300;
        @(negedge CLK);
        #1 bus.halt = 0; bus.redirect = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("s5 halted", 32'(bus.halted), 32'd1);
            chk("s5 ren", 32'(bus.imemREN), 32'd0);
            #1 bus.ihit = 1'($urandom); bus.redirect = 1'($urandom);
        end
        bus.ihit = 1;
        do_reset();
        #1 chk("s5 restart", bus.imemaddr, 32'h0);
        chk("s5 unhalt", 32'(bus.halted), 32'd0);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            #1;
            RST = ($urandom_range(0, 199) == 0) || (bus.halted && $urandom_range(0, 19) == 0);
            bus.ihit = $urandom_range(0, 2) != 0;
            bus.instr_ready = $urandom_range(0, 3) != 0;
            bus.redirect = $urandom_range(0, 9) == 0;
            bus.redirect_addr = $urandom;
            bus.halt = $urandom_range(0, 29) == 0;
        end
        @(negedge CLK);
        armed = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
